// File: rtl/pll_lock_detect.sv
// Lock detector for a divided clock: measures each half-period of clk_div in
// CLK cycles and declares lock after LOCK_CNT consecutive in-tolerance halves.
module pll_lock_detect #(
  parameter int unsigned EXP_HALF = 5,
  parameter int unsigned TOL      = 0,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CW       = 5
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          clk_div,
  output logic          lock,
  output logic          err,
  output logic [CW-1:0] half_cnt,
  output logic [7:0]    fail_cnt
);

  localparam int unsigned MW = CW + 1;
  localparam int unsigned GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_TO    = CW'(TIMEOUT - 1);
  localparam logic [MW-1:0] EXP_M     = MW'(EXP_HALF);
  localparam logic [MW-1:0] TOL_M     = MW'(TOL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state;
  logic          sync1, sync2, sync3;
  logic [CW-1:0] cnt;
  logic [GW-1:0] good_cnt;

  logic          div_edge;
  logic          timeout;
  logic          good;
  logic          fault;
  logic [MW-1:0] measured;
  logic [MW-1:0] diff;
  logic [CW-1:0] half_sat;

  // Two-flop synchronizer plus a delay stage for edge detection
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= clk_div;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Half-period counter, saturating at TIMEOUT
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (div_edge) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    div_edge = sync2 ^ sync3;
    measured = MW'(cnt) + MW'(1);
    diff     = (measured >= EXP_M) ? (measured - EXP_M) : (EXP_M - measured);
    good     = (diff <= TOL_M);
    half_sat = measured[CW] ? '1 : measured[CW-1:0];
    // Edge takes priority: a timeout only counts in a cycle without an edge
    timeout  = !div_edge && (cnt == CNT_TO);
    fault    = 1'b0;
    if (state == MEASURE || state == LOCKED) begin
      fault = div_edge ? !good : timeout;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      lock     <= 1'b0;
      err      <= 1'b0;
      half_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      err <= fault;
      if (fault && (fail_cnt != 8'hFF)) begin
        fail_cnt <= fail_cnt + 8'd1;
      end
      case (state)
        IDLE: begin
          lock <= 1'b0;
          if (div_edge) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (div_edge) begin
            half_cnt <= half_sat;
            if (good) begin
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == GOOD_LAST) begin
                state <= LOCKED;
                lock  <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state    <= IDLE;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (div_edge) begin
            half_cnt <= half_sat;
            if (!good) begin
              state    <= MEASURE;
              lock     <= 1'b0;
              good_cnt <= '0;
            end
          end else if (timeout) begin
            state    <= IDLE;
            lock     <= 1'b0;
            good_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock     <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_detect.md
PLL_LOCK_DETECT -- requirements
Module: pll_lock_detect

Interface
REQ-001 Parameter EXP_HALF, default 5, expected half-period of the divided clock, in CLK cycles.
REQ-002 Parameter TOL, default 0, allowed deviation of a measured half-period from EXP_HALF, in CLK cycles.
REQ-003 Parameter LOCK_CNT, default 4, number of consecutive good half-periods required to assert lock.
REQ-004 Parameter TIMEOUT, default 16, maximum CLK cycles without a divided-clock edge; must be > EXP_HALF+TOL.
REQ-005 Parameter CW, default 5, width of the period counter; 2^CW must be > TIMEOUT.
REQ-006 CLK  input  1  single clock for the block, rising-edge active.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 clk_div  input  1  divided clock under check, asynchronous to CLK.
REQ-009 lock  output  1  high while the divided clock is within tolerance.
REQ-010 err  output  1  one-cycle pulse on each bad half-period or timeout.
REQ-011 half_cnt  output  CW  last measured half-period, in CLK cycles.
REQ-012 fail_cnt  output  8  saturating count of err pulses since reset.

Function
REQ-013 clk_div SHALL pass through a 2-flop synchronizer, then a third register; edge = stage2 XOR stage3; both rising and falling edges count.
REQ-014 Period counter cnt SHALL be cleared to 0 in an edge cycle and incremented by 1 in every other cycle, saturating at TIMEOUT.
REQ-015 In an edge cycle, measured = cnt+1; for a clk_div toggling every 5 CLK cycles, measured = 5.
REQ-016 A half-period is good when |measured − EXP_HALF| <= TOL, computed without wrap (CW+1-bit compare).
REQ-017 FSM states: IDLE (no reference edge), MEASURE (counting good halves), LOCKED.
REQ-018 IDLE: the first edge SHALL move the FSM to MEASURE with good_cnt=0; no measurement is taken and no err is raised.
REQ-019 MEASURE, good edge: half_cnt<=measured and good_cnt++; when good_cnt reaches LOCK_CNT, go to LOCKED.
REQ-020 MEASURE, bad edge: half_cnt<=measured, good_cnt<=0, err pulse, stay in MEASURE.
REQ-021 LOCKED, good edge: half_cnt<=measured, stay in LOCKED; bad edge: err pulse, go to MEASURE, good_cnt<=0.
REQ-022 In MEASURE or LOCKED, cnt reaching TIMEOUT with no edge: err pulse, go to IDLE, good_cnt<=0; no further err until the next edge.
REQ-023 lock SHALL be registered, =1 exactly when state is LOCKED, rising the cycle after the LOCK_CNT-th good edge and falling the cycle after a bad edge or timeout.
REQ-024 fail_cnt SHALL increment on every err pulse and hold at 255.
REQ-025 An edge and a timeout in the same cycle: the edge wins; no timeout is taken.
REQ-026 In IDLE, cnt SHALL hold at TIMEOUT without raising err.

Reset
REQ-027 While reset=0: all sync flops 0, cnt=0, good_cnt=0, state IDLE, lock=0, err=0, half_cnt=0, fail_cnt=0.
REQ-028 Asserting reset mid-operation SHALL clear all state immediately, without waiting for CLK.
REQ-029 After reset is released, the first synchronized edge is treated as a fresh IDLE start.

Verification
REQ-030 Defaults; clk_div toggles every 5 CLK -> lock=1 after the 5th edge (1 reference + 4 good), half_cnt=5, err never set, fail_cnt=0.
REQ-031 Locked; one half-period stretched to 7 -> err for 1 cycle, lock=0 the next cycle, half_cnt=7, fail_cnt=1, relock after 4 more good halves.
REQ-032 Locked; clk_div held constant -> err pulse 16 cycles after the last edge, lock=0, state IDLE, fail_cnt=1, no second err.
REQ-033 TOL=1, half-periods alternating 4 and 6 -> lock asserts; a half-period of 3 -> err, lock drops.
REQ-034 reset driven low asynchronously while locked -> lock, err, half_cnt and fail_cnt = 0 with no CLK edge required.
REQ-035 Force 300 bad half-periods -> fail_cnt saturates at 255.
